// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and a two-entry skid buffer.
// Empty or flushed slots present all-zero control so they behave as bubbles.
module pipe_stage_skid #(
    parameter int unsigned CTRL_W = 2,
    parameter int unsigned DATA_W = 69
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                in_fire, out_fire;

    assign out_valid = (state_q != StEmpty);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    state_d     = StOne;
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end
            end
            StOne: begin
                if (in_fire && out_fire) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end else if (in_fire) begin
                    state_d     = StFull;
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end else if (out_fire) begin
                    state_d     = StEmpty;
                    main_ctrl_d = '0;
                end
            end
            StFull: begin
                if (out_fire) begin
                    state_d     = StOne;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                end
            end
            default: begin
                state_d     = StEmpty;
                main_ctrl_d = '0;
            end
        endcase

        // Flush drops both entries; data is left stale since ctrl=0 marks the bubble.
        if (flush) begin
            state_d     = StEmpty;
            main_ctrl_d = '0;
        end

        in_ready_d = (state_d != StFull);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: default-width instance plus two width-sweep instances.
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Default-width DUT
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [1:0]  in_ctrl, out_ctrl, occupancy;
    logic [68:0] in_data, out_data;

    pipe_stage_skid dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    // Sweep DUTs share handshake controls
    logic        sw_valid, sw_ready, sw_flush;
    logic [0:0]  c1_in, d1_in, c1_out, d1_out;
    logic [3:0]  c4_in, c4_out;
    logic [99:0] d4_in, d4_out;
    logic        r1, r4, v1, v4;
    logic [1:0]  o1, o4;

    pipe_stage_skid #(.CTRL_W(1), .DATA_W(1)) dut1 (
        .clk (clk), .rst (rst), .in_valid (sw_valid), .in_ready (r1), .in_ctrl (c1_in),
        .in_data (d1_in), .flush (sw_flush), .out_valid (v1), .out_ready (sw_ready),
        .out_ctrl (c1_out), .out_data (d1_out), .occupancy (o1)
    );

    pipe_stage_skid #(.CTRL_W(4), .DATA_W(100)) dut4 (
        .clk (clk), .rst (rst), .in_valid (sw_valid), .in_ready (r4), .in_ctrl (c4_in),
        .in_data (d4_in), .flush (sw_flush), .out_valid (v4), .out_ready (sw_ready),
        .out_ctrl (c4_out), .out_data (d4_out), .occupancy (o4)
    );

    typedef struct {
        logic [1:0]  ctrl;
        logic [68:0] data;
        int          acc_cyc;
        bit          lat;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops on every output fire and checks bubble control-zeroing
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got data %0h expected none", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_ctrl", 128'(out_ctrl), 128'(e.ctrl));
                    chk("out_data", 128'(out_data), 128'(e.data));
                    if (e.lat) chk("latency", 128'(cyc), 128'(e.acc_cyc + 1));
                end
            end
            if (out_valid === 1'b0) chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [68:0] d, input bit lat);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1 && flush === 1'b0) begin
                exp_q.push_back('{c, d, cyc, lat});
                step();
                return;
            end
            step();
        end
        total++;
        bad++;
        $display("FAIL send_timeout: word %0h not accepted within 20 cycles", d);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic sw_drive(input logic c1, input logic d1, input logic [3:0] c4,
                            input logic [99:0] d4);
        sw_valid = 1'b1;
        c1_in = c1; d1_in = d1; c4_in = c4; d4_in = d4;
    endtask

    task automatic sw_out(input string name, input logic c1, input logic d1,
                          input logic [3:0] c4, input logic [99:0] d4);
        chk({name, "_v1"}, 128'(v1), 128'(1));
        chk({name, "_c1"}, 128'(c1_out), 128'(c1));
        chk({name, "_d1"}, 128'(d1_out), 128'(d1));
        chk({name, "_v4"}, 128'(v4), 128'(1));
        chk({name, "_c4"}, 128'(c4_out), 128'(c4));
        chk({name, "_d4"}, 128'(d4_out), 128'(d4));
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [99:0] ones4, alt4, alt4b;
        ones4 = '1;
        alt4  = {50{2'b10}};
        alt4b = {50{2'b01}};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 2'b11; in_data = 69'h77;
        sw_valid = 1'b0; sw_ready = 1'b0; sw_flush = 1'b0;
        c1_in = '0; d1_in = '0; c4_in = '0; d4_in = '0;

        // Reset with an input presented: nothing accepted
        repeat (2) step();
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_occupancy", 128'(occupancy), 128'(0));
        step();

        // Streaming 1..8 back to back
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_ctrl = 2'b11; in_data = 69'(i);
            @(negedge clk);
            chk("stream_in_ready", 128'(in_ready), 128'(1));
            exp_q.push_back('{2'b11, 69'(i), cyc, 1'b1});
            step();
        end
        idle(3);
        chk("stream_drained", 128'(exp_q.size()), 128'(0));

        // Skid: A accepted, then out_ready drops while B is taken into the skid
        send(2'b11, 69'hA, 1'b0);
        out_ready = 1'b0;
        send(2'b11, 69'hB, 1'b0);
        in_valid = 1'b1; in_ctrl = 2'b11; in_data = 69'hC;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("skid_in_ready", 128'(in_ready), 128'(0));
            chk("skid_occupancy", 128'(occupancy), 128'(2));
            chk("skid_out_data", 128'(out_data), 128'(69'hA));
            chk("skid_out_valid", 128'(out_valid), 128'(1));
            step();
        end
        out_ready = 1'b1;
        send(2'b11, 69'hC, 1'b0);
        idle(4);
        chk("skid_drained", 128'(exp_q.size()), 128'(0));

        // Flush while FULL with D presented
        out_ready = 1'b0;
        send(2'b01, 69'h21, 1'b0);
        send(2'b01, 69'h22, 1'b0);
        in_valid = 1'b1; in_ctrl = 2'b11; in_data = 69'hD; flush = 1'b1;
        @(negedge clk);
        exp_q.delete();
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_full_out_valid", 128'(out_valid), 128'(0));
        chk("flush_full_out_ctrl", 128'(out_ctrl), 128'(0));
        chk("flush_full_occupancy", 128'(occupancy), 128'(0));
        chk("flush_full_in_ready", 128'(in_ready), 128'(1));
        step();

        // Flush in ONE while a word fires in: that word is discarded
        send(2'b01, 69'h31, 1'b0);
        in_valid = 1'b1; in_ctrl = 2'b11; in_data = 69'hE; flush = 1'b1;
        @(negedge clk);
        exp_q.delete();
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_one_occupancy", 128'(occupancy), 128'(0));
        chk("flush_one_out_valid", 128'(out_valid), 128'(0));
        step();
        out_ready = 1'b1;
        idle(3);
        send(2'b01, 69'h30, 1'b1);
        idle(2);

        // Bubbles between 0x5 and 0x6
        send(2'b10, 69'h5, 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("bubble_valid", 128'(out_valid), 128'(0));
                chk("bubble_zero_ctrl", 128'(out_ctrl), 128'(0));
            end
            step();
        end
        send(2'b10, 69'h6, 1'b1);
        idle(3);

        // Width sweep: streaming all-ones then alternating bits
        sw_ready = 1'b1;
        sw_drive(1'b1, 1'b1, 4'hF, ones4);
        @(negedge clk);
        chk("sw_r1", 128'(r1), 128'(1));
        chk("sw_r4", 128'(r4), 128'(1));
        step();
        sw_drive(1'b1, 1'b0, 4'b1010, alt4);
        @(negedge clk);
        sw_out("sw_ones", 1'b1, 1'b1, 4'hF, ones4);
        step();
        sw_valid = 1'b0;
        @(negedge clk);
        sw_out("sw_alt", 1'b1, 1'b0, 4'b1010, alt4);
        step();
        @(negedge clk);
        chk("sw_bubble_c1", 128'(c1_out), 128'(0));
        chk("sw_bubble_c4", 128'(c4_out), 128'(0));
        step();

        // Width sweep: skid
        sw_drive(1'b1, 1'b1, 4'hF, ones4);
        step();
        sw_ready = 1'b0;
        sw_drive(1'b1, 1'b0, 4'b1010, alt4);
        step();
        sw_drive(1'b1, 1'b1, 4'b0101, alt4b);
        @(negedge clk);
        chk("sw_skid_r1", 128'(r1), 128'(0));
        chk("sw_skid_r4", 128'(r4), 128'(0));
        chk("sw_skid_o1", 128'(o1), 128'(2));
        chk("sw_skid_o4", 128'(o4), 128'(2));
        sw_out("sw_skid_hold", 1'b1, 1'b1, 4'hF, ones4);
        step();
        sw_ready = 1'b1;
        step();
        @(negedge clk);
        sw_out("sw_skid_second", 1'b1, 1'b0, 4'b1010, alt4);
        chk("sw_skid_r4_back", 128'(r4), 128'(1));
        step();
        sw_valid = 1'b0;
        @(negedge clk);
        sw_out("sw_skid_third", 1'b1, 1'b1, 4'b0101, alt4b);
        step();
        @(negedge clk);
        chk("sw_end_o1", 128'(o1), 128'(0));
        chk("sw_end_o4", 128'(o4), 128'(0));
        step();

        idle(2);
        chk("final_drain", 128'(exp_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and bubble control-zeroing. It replaces fixed-width, always-loading stage latches such as the memory-to-writeback stage between any two processor stages. The stage carries a control field and a data payload, so a stalled downstream stage never loses an instruction. An empty or flushed slot always presents all-zero control, so it acts as a bubble that writes nothing.

## Interface
Parameters:
- CTRL_W, default 2: control field width; field is zeroed whenever the slot is invalid.
- DATA_W, default 69: payload width (default = 32 read data + 32 ALU result + 5 dest register).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  upstream presents a word.
- in_ready  out  1  stage can accept; registered.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  discard all held words this cycle.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control field; 0 whenever out_valid=0.
- out_data  out  DATA_W  payload.
- occupancy  out  2  words held: 0, 1 or 2.

## Operation
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register drives the outputs; skid register holds a second word.
- States: EMPTY (occupancy 0), ONE (1), FULL (2).
- in_ready = 1 in EMPTY and ONE; 0 in FULL. It is registered and derived from the next state.
- EMPTY:
  - in_fire → ONE, main ← in.
- ONE:
  - in_fire & out_fire → ONE, main ← in.
  - in_fire & !out_ready → FULL, skid ← in, main unchanged.
  - !in_fire & out_fire → EMPTY.
  - otherwise hold.
- FULL:
  - out_fire → ONE, main ← skid. An input is impossible because in_ready=0.
  - otherwise hold.
- Ordering: strictly FIFO; words never reorder, duplicate or drop, except on flush or reset.
- Bubbles: out_ctrl is forced to 0 in EMPTY. out_data keeps its last value in EMPTY and is don't-care downstream.
- flush:
  - Next state is EMPTY, out_valid=0, out_ctrl=0, in_ready=1.
  - An in_fire in the same cycle is discarded.
  - flush has priority over all transitions.
- rst has priority over flush. Inputs are ignored while rst=1.

## Timing
- Reset values after the first rising edge with rst=1: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0, skid contents=0.
- Latency: a word accepted at edge N appears on the outputs after edge N, i.e. 1 cycle, when the stage was EMPTY or out_fire coincides.
- Throughput: 1 word/cycle sustained with out_ready=1.
- Stall response: when out_ready drops, one extra word is absorbed into the skid. in_ready deasserts on the following cycle, not combinationally.
- No combinational path from out_ready to in_ready. Every output is registered.
- A flush or rst asserted mid-stall empties both entries in one edge. A word may be accepted on the next cycle.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1 and in_ctrl=2'b11 → out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1. No word is accepted.
- Streaming: out_ready=1; words 1..8 presented back-to-back with ctrl=2'b11 → out_data 1..8 on consecutive cycles, each 1 cycle after acceptance, with in_ready constantly 1.
- Skid: stream 0xA, 0xB, 0xC with out_ready=0 from the cycle after 0xA is accepted → 0xA held on output, 0xB in skid, occupancy=2, in_ready=0, 0xC held off. Release out_ready → 0xA, 0xB, 0xC delivered in order with no loss.
- Flush while FULL with in_valid=1 (word 0xD) → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. 0xD is never output.
- Bubble: in_valid=0 for 3 cycles between words 0x5 and 0x6 → out_ctrl=0 on those cycles while out_valid=0. 0x5 and 0x6 keep their ctrl (2'b10).
- Parameter sweep: CTRL_W=1, DATA_W=1 and CTRL_W=4, DATA_W=100 → all-ones and alternating-bit payloads pass bit-exact. Streaming and skid scenarios pass unchanged.
